// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request and result/flag bundle for alu_seq_core.
// master drives start/op/a/b; slave returns busy/done/result/result_hi/flags/err.
interface alu_seq_if #(
  parameter int N   = 4,
  parameter int OPW = 4
);
  logic           start;
  logic [OPW-1:0] op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [N-1:0]   result;
  logic [N-1:0]   result_hi;
  logic           flag_z;
  logic           flag_n;
  logic           flag_v;
  logic           flag_c;
  logic           err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, result_hi,
    input  flag_z, flag_n, flag_v, flag_c, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, result_hi,
    output flag_z, flag_n, flag_v, flag_c, err
  );
endinterface

// File: rtl/alu_seq_core.sv
// alu_seq_core: N-bit ALU, iterative mul/div/mod, held result + flags.
// Ports: clk, rst_n (sync, active-low), bus (alu_seq_if.slave). Option: ALU_SAT_EN.
module alu_seq_core #(
  parameter int N   = 4,
  parameter int OPW = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_MUL = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV = OPW'(3);
  localparam logic [OPW-1:0] OP_MOD = OPW'(4);
  localparam logic [OPW-1:0] OP_AND = OPW'(5);
  localparam logic [OPW-1:0] OP_OR  = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR = OPW'(7);
  localparam logic [OPW-1:0] OP_SHL = OPW'(8);
  localparam logic [OPW-1:0] OP_SHR = OPW'(9);

  typedef enum logic [1:0] {IDLE, ITER, FIN} st_t;

  st_t            st;
  logic [CW-1:0]  cnt;
  logic [OPW-1:0] rop;
  logic [N-1:0]   ra, rb, hi, lo;
  logic           busy_q, done_q;
  logic [N-1:0]   res_q, rhi_q;
  logic           z_q, n_q, v_q, c_q, err_q;

  logic go_iter;
  assign go_iter = (bus.op == OP_MUL || bus.op == OP_DIV
                    || bus.op == OP_MOD) && (bus.b != '0);

  // mul: {hi,lo} is the shift-add accumulator, lo starts as multiplier
  logic [N:0] madd;
  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, ra} : '0);

  // div: hi is partial remainder, lo shifts dividend out / quotient in
  logic [N:0] dsh, dsub;
  logic       dge;
  assign dsh  = {hi, lo[N-1]};
  assign dge  = dsh >= {1'b0, rb};
  assign dsub = dsh - {1'b0, rb};

  logic [N:0]     sum, dif;
  logic [2*N-1:0] shl_w, shr_w;
  assign sum   = {1'b0, ra} + {1'b0, rb};
  assign dif   = {1'b0, ra} + {1'b0, ~rb} + (N+1)'(1);
  // widened shifts: the bit next to the result is the last one shifted out
  assign shl_w = {{N{1'b0}}, ra} << rb;
  assign shr_w = {ra, {N{1'b0}}} >> rb;

  logic [N-1:0] f_res, f_hi;
  logic         f_z, f_n, f_v, f_c, f_err;

  always_comb begin
    f_res = '0;
    f_hi  = '0;
    f_v   = 1'b0;
    f_c   = 1'b0;
    f_err = 1'b0;
    unique case (1'b1)
      rop == OP_ADD: begin
        f_res = sum[N-1:0];
        f_c   = sum[N];
        f_v   = (ra[N-1] == rb[N-1]) && (sum[N-1] != ra[N-1]);
`ifdef ALU_SAT_EN
        if (sum[N]) f_res = '1;
`endif
      end
      rop == OP_SUB: begin
        f_res = dif[N-1:0];
        f_c   = dif[N];
        f_v   = (ra[N-1] != rb[N-1]) && (dif[N-1] != ra[N-1]);
`ifdef ALU_SAT_EN
        if (!dif[N]) f_res = '0;
`endif
      end
      rop == OP_MUL: begin
        f_res = lo;
        f_hi  = hi;
        f_c   = |hi;
        f_v   = |hi;
      end
      (rop == OP_DIV || rop == OP_MOD) && rb == '0: begin
        f_res = '1;
        f_hi  = ra;
        f_err = 1'b1;
      end
      rop == OP_DIV && rb != '0: begin
        f_res = lo;
        f_hi  = hi;
      end
      rop == OP_MOD && rb != '0: f_res = hi;
      rop == OP_AND: f_res = ra & rb;
      rop == OP_OR:  f_res = ra | rb;
      rop == OP_XOR: f_res = ra ^ rb;
      rop == OP_SHL: begin
        f_res = shl_w[N-1:0];
        f_c   = shl_w[N];
      end
      rop == OP_SHR: begin
        f_res = shr_w[2*N-1:N];
        f_c   = shr_w[N-1];
      end
      default: f_err = 1'b1;
    endcase
    f_n = f_res[N-1];
    f_z = (rop == OP_MUL) ? ({hi, lo} == '0) : (f_res == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= '0;
      rop    <= '0;
      ra     <= '0;
      rb     <= '0;
      hi     <= '0;
      lo     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      rhi_q  <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      c_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            rop    <= bus.op;
            ra     <= bus.a;
            rb     <= bus.b;
            hi     <= '0;
            // mul by zero skips ITER; lo=b=0 then yields a zero product
            lo     <= (bus.op == OP_MUL) ? bus.b : bus.a;
            cnt    <= CW'(N-1);
            busy_q <= 1'b1;
            st     <= go_iter ? ITER : FIN;
          end
        end
        ITER: begin
          if (rop == OP_MUL) begin
            hi <= madd[N:1];
            lo <= {madd[0], lo[N-1:1]};
          end else begin
            hi <= dge ? dsub[N-1:0] : dsh[N-1:0];
            lo <= {lo[N-2:0], dge};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) st <= FIN;
        end
        FIN: begin
          res_q  <= f_res;
          rhi_q  <= f_hi;
          z_q    <= f_z;
          n_q    <= f_n;
          v_q    <= f_v;
          c_q    <= f_c;
          err_q  <= f_err;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.result_hi = rhi_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_c    = c_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed + random stimulus for alu_seq_core,
// checked every cycle against an arithmetic reference model.
module tb_alu_seq_core;
  localparam int N   = 4;
  localparam int OPW = 4;
  localparam longint M = (longint'(1) << N) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N), .OPW(OPW)) bus();

  alu_seq_core #(.N(N), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    longint res;
    longint hi;
    bit     z, n, v, c, err;
    int     lat;
  } exp_t;

  int n_chk = 0;
  int n_pass = 0;

  function automatic exp_t zero_e();
    exp_t e;
    e.res = 0; e.hi = 0;
    e.z = 0; e.n = 0; e.v = 0; e.c = 0; e.err = 0;
    e.lat = 1;
    return e;
  endfunction

  function automatic longint sgn(longint x);
    return (x >= (longint'(1) << (N-1))) ? x - (longint'(1) << N) : x;
  endfunction

  function automatic bit ovf(longint s);
    return (s > (longint'(1) << (N-1)) - 1) || (s < -(longint'(1) << (N-1)));
  endfunction

  function automatic exp_t model(int op, longint a, longint b);
    exp_t e;
    longint s;
    e = zero_e();
    case (op)
      0: begin
        s = a + b;
        e.res = s & M;
        e.c = s > M;
        e.v = ovf(sgn(a) + sgn(b));
`ifdef ALU_SAT_EN
        if (e.c) e.res = M;
`endif
      end
      1: begin
        s = a - b;
        e.res = s & M;
        e.c = a >= b;
        e.v = ovf(sgn(a) - sgn(b));
`ifdef ALU_SAT_EN
        if (!e.c) e.res = 0;
`endif
      end
      2: begin
        s = a * b;
        e.res = s & M;
        e.hi = s >> N;
        e.c = e.hi != 0;
        e.v = e.c;
        if (b != 0) e.lat = N + 1;
      end
      3, 4: begin
        if (b == 0) begin
          e.res = M;
          e.hi = a;
          e.err = 1;
        end else begin
          e.res = (op == 3) ? a / b : a % b;
          e.hi = (op == 3) ? a % b : 0;
          e.lat = N + 1;
        end
      end
      5: e.res = a & b;
      6: e.res = a | b;
      7: e.res = a ^ b;
      8: begin
        e.res = (b < N) ? ((a << b) & M) : 0;
        e.c = (b >= 1 && b <= N) ? (((a >> (N - b)) & 1) != 0) : 1'b0;
      end
      9: begin
        e.res = (b < N) ? (a >> b) : 0;
        e.c = (b >= 1 && b <= N) ? (((a >> (b - 1)) & 1) != 0) : 1'b0;
      end
      default: e.err = 1;
    endcase
    e.n = ((e.res >> (N-1)) & 1) != 0;
    e.z = (op == 2) ? (a * b == 0) : (e.res == 0);
    return e;
  endfunction

  // reference timeline: cycles left until the pending op completes
  exp_t pend, out;
  int   left = 0;
  bit   m_busy = 0;
  bit   m_done = 0;

  initial out = zero_e();

  always @(posedge clk) begin
    if (!rst_n) begin
      left = 0;
      m_busy = 0;
      m_done = 0;
      out = zero_e();
    end else begin
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          out = pend;
          m_done = 1;
          m_busy = 0;
        end
      end else if (bus.start) begin
        pend = model(int'(bus.op), longint'(bus.a), longint'(bus.b));
        left = pend.lat;
        m_busy = 1;
      end
    end
  end

  logic [2*N+6:0] got_v, exp_v;
  always @(negedge clk) begin
    got_v = {bus.busy, bus.done, bus.result, bus.result_hi,
             bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c, bus.err};
    exp_v = {m_busy, m_done, N'(out.res), N'(out.hi),
             out.z, out.n, out.v, out.c, out.err};
    n_chk++;
    if (got_v === exp_v) n_pass++;
    else $display("FAIL cycle_cmp t=%0t got=%h exp=%h (busy,done,res,hi,z,n,v,c,err)",
                  $time, got_v, exp_v);
  end

  task automatic lit(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic run(input int op, input int a, input int b,
                     input bit poke, output int lat);
    bus.start = 1'b1;
    bus.op = OPW'(op);
    bus.a = N'(a);
    bus.b = N'(b);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      // stray requests while busy must be ignored
      if (poke) begin
        bus.start = (lat == 0 || lat == 2);
        bus.op = OPW'(0);
        bus.a = N'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    lit("done_seen", longint'(bus.done), 1);
  endtask

  int  l;
  bit  seen;

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    lit("rst_result", bus.result, 0);
    lit("rst_busy", bus.busy, 0);
    lit("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_v, bus.flag_c, bus.err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 7, 9, 0, l);
    lit("add_lat", l, 1);
`ifdef ALU_SAT_EN
    lit("add_res", bus.result, 'hF);
    lit("add_z", bus.flag_z, 0);
`else
    lit("add_res", bus.result, 0);
    lit("add_z", bus.flag_z, 1);
`endif
    lit("add_c", bus.flag_c, 1);
    lit("add_v", bus.flag_v, 0);
    lit("add_n", bus.flag_n, 0);

    run(1, 3, 5, 0, l);
`ifdef ALU_SAT_EN
    lit("sub_res", bus.result, 0);
    lit("sub_n", bus.flag_n, 0);
`else
    lit("sub_res", bus.result, 'hE);
    lit("sub_n", bus.flag_n, 1);
`endif
    lit("sub_c", bus.flag_c, 0);
    lit("sub_v", bus.flag_v, 0);

    run(1, 8, 1, 0, l);
    lit("sub2_res", bus.result, 7);
    lit("sub2_v", bus.flag_v, 1);
    lit("sub2_c", bus.flag_c, 1);

    run(2, 7, 6, 1, l);
    lit("mul_lat", l, 5);
    lit("mul_res", bus.result, 'hA);
    lit("mul_hi", bus.result_hi, 2);
    lit("mul_vc", {bus.flag_v, bus.flag_c}, 3);

    run(3, 13, 4, 0, l);
    lit("div_lat", l, N + 1);
    lit("div_q", bus.result, 3);
    lit("div_r", bus.result_hi, 1);

    run(3, 9, 0, 0, l);
    lit("dz_lat", l, 1);
    lit("dz_res", bus.result, 'hF);
    lit("dz_hi", bus.result_hi, 9);
    lit("dz_err", bus.err, 1);

    run(12, 5, 5, 0, l);
    lit("ill_res", bus.result, 0);
    lit("ill_ez", {bus.err, bus.flag_z}, 3);

    run(8, 3, 3, 0, l);
    lit("shl_res", bus.result, 8);
    lit("shl_c", bus.flag_c, 1);
    run(9, 6, 4, 0, l);
    lit("shr4_res", bus.result, 0);
    lit("shr4_c", bus.flag_c, 0);
    run(9, 5, 1, 0, l);
    lit("shr1_res", bus.result, 2);
    lit("shr1_c", bus.flag_c, 1);

    run(4, 13, 4, 0, l);
    lit("mod_res", bus.result, 1);
    lit("mod_hi", bus.result_hi, 0);

    // abort a mul with reset sampled on its 3rd ITER edge
    bus.start = 1'b1;
    bus.op = OPW'(2);
    bus.a = N'(7);
    bus.b = N'(6);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    lit("abort_res", bus.result, 0);
    lit("abort_busy", bus.busy, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    lit("abort_no_done", seen, 0);
    run(0, 2, 3, 0, l);
    lit("post_rst_add", bus.result, 5);
    lit("post_rst_lat", l, 1);

    // random traffic, including back-to-back and stray starts and resets
    repeat (3000) begin
      bus.start = ($urandom % 3) == 0;
      bus.op = ($urandom % 8 == 0) ? OPW'(10 + $urandom % 6)
                                   : OPW'($urandom % 10);
      bus.a = N'($urandom);
      bus.b = ($urandom % 6 == 0) ? '0 : N'($urandom);
      rst_n = ($urandom % 300) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (N + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised N-bit ALU core with a registered start/done handshake and flag register.
- Supports the ten-operation set (add, sub, mul, div, mod, and, or, xor, shl, shr).
- MUL/DIV/MOD run as N-cycle shift-add / restoring iterations instead of combinational arrays.
- Sits between the board operation selector / 7-seg display logic and the operands. Results and flags are held stable between operations for display.

Parameters:
- N, 4, operand/result width; legal values 2..32.
- OPW, 4, opcode width; must be >= 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  OPW  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 shl, 9 shr; 10+ illegal
- a  in  N  operand A (dividend, shift source)
- b  in  N  operand B (divisor, shift amount)
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse: result/flags updated
- result  out  N  low result / quotient / remainder(mod)
- result_hi  out  N  mul upper half; div remainder; 0 otherwise
- flag_z, flag_n, flag_v, flag_c  out  1 each  zero, negative, overflow, carry
- err  out  1  illegal opcode or divide-by-zero on last op

Behaviour:
- Reset: clk and rst_n only; rst_n is synchronous, active-low.
  - rst_n=0 at an edge forces state IDLE.
  - busy, done, result, result_hi, all flags and err are set to 0.
  - Reset mid-operation aborts it: no done, outputs cleared.
- States: IDLE, ITER, FIN.
  - IDLE: start=1 at edge k latches a, b, op.
  - Single-cycle ops (add, sub, logic, shifts, illegal, div/mod by zero): outputs update and done=1 after edge k+1; stay IDLE.
  - mul/div/mod with b!=0: go to ITER with counter=N-1, busy=1. ITER runs N edges (k+1..k+N), then FIN. FIN updates outputs, done=1, busy=0 after edge k+N+1, returns to IDLE.
- start while busy=1 is ignored. start in the same cycle done=1 (IDLE) is accepted, so back-to-back ops are allowed.
- Outputs hold their values until the next done or reset. err updates with every done.
- Arithmetic (unsigned datapath; N and V flags use signed interpretation):
  - add: {c,r}=a+b. V = signed overflow.
  - sub: r=a+~b+1. C = carry out (1 = no borrow). V = signed overflow.
  - mul: 2N-bit unsigned product, {result_hi,result}. V=C=(result_hi!=0). Z is on the full 2N product.
  - div: result=quotient, result_hi=remainder. mod: result=remainder, result_hi=0. V=C=0.
  - div/mod by b=0: result=all ones, result_hi=a, err=1, Z=0, N=result[N-1], V=C=0; single cycle.
  - shl/shr (logical): b>=N gives result 0. C = last bit shifted out; 0 when b=0 or b>N. V=0.
  - Logic ops: V=C=0.
  - Illegal op: result=0, result_hi=0, err=1, Z=1, N=V=C=0.
- Flags for all ops: Z=(result==0) except mul; N=result[N-1].

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: add and sub saturate unsigned. Add with carry gives result=all ones; sub with borrow (C=0) gives result=0. C and V reflect the unsaturated operation; Z and N reflect the saturated output.
- Undefined: add and sub wrap modulo 2^N, and the saturation logic is not present.

Test Plan (N=4):
- add a=7, b=9 -> result=0, Z=1, C=1, V=0, N=0, done 1 cycle after start. Same with ALU_SAT_EN -> result=F, Z=0, C=1.
- sub a=3, b=5 -> result=E, N=1, C=0, V=0. sub a=8, b=1 -> result=7, V=1, C=1.
- mul a=7, b=6 -> result=A, result_hi=2, V=C=1. busy high 5 cycles, done exactly 5 cycles after start. start pulses during busy are ignored.
- div a=13, b=4 -> result=3, result_hi=1, done at N+1. div a=9, b=0 -> result=F, result_hi=9, err=1, done after 1 cycle. op=12 -> result=0, err=1, Z=1.
- shl a=3, b=3 -> result=8, C=1. shr a=6, b=4 -> result=0, C=0. shr a=5, b=1 -> result=2, C=1.
- mul started, rst_n=0 on 3rd ITER cycle -> all outputs 0, no done. New add issued after reset completes normally.
